// File: rtl/lifo_stack_param.sv
// Parametrised synchronous LIFO stack with independent push/pop strobes, replace-top and bypass.
// Optional sticky overflow/underflow flags and the ErrClr/OVF/UDF ports exist only when LIFO_ERR_EN is defined.
module lifo_stack_param #(
  parameter int WIDTH     = 4,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = DEPTH - 1,
  localparam int CW       = $clog2(DEPTH + 1)
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             EN,
  input  logic             Push,
  input  logic             Pop,
  input  logic [WIDTH-1:0] dataIn,
  output logic [WIDTH-1:0] dataOut,
  output logic             DataValid,
  output logic [CW-1:0]    Count,
  output logic             EMPTY,
  output logic             FULL,
  output logic             ALMOST_FULL
`ifdef LIFO_ERR_EN
  ,
  input  logic             ErrClr,
  output logic             OVF,
  output logic             UDF
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    OP_IDLE,
    OP_PUSH,
    OP_POP,
    OP_REPLACE,
    OP_BYPASS,
    OP_OVF,
    OP_UDF
  } op_t;

  logic [WIDTH-1:0] mem [DEPTH];
  op_t              op;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    top_idx;
  logic [CW-1:0]    count_dec;

  assign EMPTY       = (Count == '0);
  assign FULL        = (Count == CW'(DEPTH));
  assign ALMOST_FULL = (Count >= CW'(AF_THRESH));

  // Indices are only consumed when the decoded op guarantees they are in range.
  assign count_dec = Count - CW'(1);
  assign wr_idx    = AW'(Count);
  assign top_idx   = AW'(count_dec);

  always_comb begin
    op = OP_IDLE;
    if (EN) begin
      unique case ({Push, Pop})
        2'b10:   op = FULL  ? OP_OVF    : OP_PUSH;
        2'b01:   op = EMPTY ? OP_UDF    : OP_POP;
        2'b11:   op = EMPTY ? OP_BYPASS : OP_REPLACE;
        default: op = OP_IDLE;
      endcase
    end
  end

  // Storage array is deliberately not reset.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      if (op == OP_PUSH)    mem[wr_idx]  <= dataIn;
      if (op == OP_REPLACE) mem[top_idx] <= dataIn;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      Count     <= '0;
      dataOut   <= '0;
      DataValid <= 1'b0;
    end else begin
      DataValid <= 1'b0;
      unique case (op)
        OP_PUSH: Count <= Count + CW'(1);
        OP_POP: begin
          dataOut   <= mem[top_idx];
          DataValid <= 1'b1;
          Count     <= count_dec;
        end
        OP_REPLACE: begin
          dataOut   <= mem[top_idx];
          DataValid <= 1'b1;
        end
        OP_BYPASS: begin
          dataOut   <= dataIn;
          DataValid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef LIFO_ERR_EN
  // Set has priority over ErrClr on the same edge.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      OVF <= 1'b0;
      UDF <= 1'b0;
    end else begin
      if (op == OP_OVF)       OVF <= 1'b1;
      else if (EN && ErrClr)  OVF <= 1'b0;
      if (op == OP_UDF)       UDF <= 1'b1;
      else if (EN && ErrClr)  UDF <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_lifo_stack_param.sv
// Self-checking bench for lifo_stack_param (WIDTH=4, DEPTH=8, AF_THRESH=7): vector table plus
// hand-built full-stack replace/drain sequence, compared through a scoreboard queue.
module tb_lifo_stack_param;

  localparam int WIDTH = 4;
  localparam int DEPTH = 8;
  localparam int AFT   = 7;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             Clk = 1'b0;
  logic             Rst = 1'b0;
  logic             EN = 1'b0;
  logic             Push = 1'b0;
  logic             Pop = 1'b0;
  logic [WIDTH-1:0] dataIn = '0;
  logic [WIDTH-1:0] dataOut;
  logic             DataValid;
  logic [CW-1:0]    Count;
  logic             EMPTY;
  logic             FULL;
  logic             ALMOST_FULL;
  logic             ErrClr = 1'b0;
`ifdef LIFO_ERR_EN
  logic             OVF;
  logic             UDF;
`endif

  lifo_stack_param #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .AF_THRESH(AFT)
  ) dut (
    .Clk(Clk),
    .Rst(Rst),
    .EN(EN),
    .Push(Push),
    .Pop(Pop),
    .dataIn(dataIn),
    .dataOut(dataOut),
    .DataValid(DataValid),
    .Count(Count),
    .EMPTY(EMPTY),
    .FULL(FULL),
    .ALMOST_FULL(ALMOST_FULL)
`ifdef LIFO_ERR_EN
    ,
    .ErrClr(ErrClr),
    .OVF(OVF),
    .UDF(UDF)
`endif
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic       rst, en, push, pop, clr;
    logic [3:0] din;
    logic [3:0] e_dout;
    logic       e_dv;
    int         e_cnt;
    logic       e_ovf, e_udf;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(logic rst, logic en, logic push, logic pop, logic clr,
                              logic [3:0] din, logic [3:0] e_dout, logic e_dv, int e_cnt,
                              logic e_ovf, logic e_udf);
    vec_t v;
    v.rst = rst; v.en = en; v.push = push; v.pop = pop; v.clr = clr; v.din = din;
    v.e_dout = e_dout; v.e_dv = e_dv; v.e_cnt = e_cnt; v.e_ovf = e_ovf; v.e_udf = e_udf;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s step=%0d actual=0x%0h required=0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    @(negedge Clk);
    Rst = v.rst; EN = v.en; Push = v.push; Pop = v.pop; ErrClr = v.clr; dataIn = v.din;
    sb.push_back(v);
    @(posedge Clk);
    #1;
    e = sb.pop_front();
    check("dataOut",     idx, int'(dataOut),     int'(e.e_dout));
    check("DataValid",   idx, int'(DataValid),   int'(e.e_dv));
    check("Count",       idx, int'(Count),       e.e_cnt);
    check("EMPTY",       idx, int'(EMPTY),       int'(e.e_cnt == 0));
    check("FULL",        idx, int'(FULL),        int'(e.e_cnt == DEPTH));
    check("ALMOST_FULL", idx, int'(ALMOST_FULL), int'(e.e_cnt >= AFT));
`ifdef LIFO_ERR_EN
    check("OVF",         idx, int'(OVF),         int'(e.e_ovf));
    check("UDF",         idx, int'(UDF),         int'(e.e_udf));
`endif
  endtask

  initial begin
    logic [3:0] mdl[$];
    logic [3:0] d;
    logic [3:0] top;
    int step;

    //               rst en pu po cl din   dout dv cnt ovf udf
    vecs.push_back(mk(1, 0, 0, 0, 0, 4'h0, 4'h0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 4'h0, 4'h0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 4'h2, 4'h0, 0, 2, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 4'h4, 4'h0, 0, 3, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 4'h6, 4'h0, 0, 4, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 0, 4'h0, 4'h6, 1, 3, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 0, 4'h0, 4'h4, 1, 2, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 0, 4'h0, 4'h2, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 0, 4'h0, 4'h0, 1, 0, 0, 0));
    for (int i = 1; i <= 8; i++)
      vecs.push_back(mk(0, 1, 1, 0, 0, 4'(i), 4'h0, 0, i, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 4'hF, 4'h0, 0, 8, 1, 0));   // overflow
    vecs.push_back(mk(0, 1, 0, 1, 0, 4'h0, 4'h8, 1, 7, 1, 0));
    for (int i = 0; i < 3; i++)                                     // EN=0 gating
      vecs.push_back(mk(0, 0, 1, 0, 1, 4'h7, 4'h8, 0, 7, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 4'h0, 4'h8, 0, 7, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 4'h0, 4'h0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 4'h3, 4'h0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 4'h5, 4'h0, 0, 2, 0, 0));
    vecs.push_back(mk(0, 1, 1, 1, 0, 4'h9, 4'h5, 1, 2, 0, 0));   // replace top
    vecs.push_back(mk(0, 1, 0, 1, 0, 4'h0, 4'h9, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 0, 4'h0, 4'h3, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 1, 0, 4'hA, 4'hA, 1, 0, 0, 0));   // bypass
    vecs.push_back(mk(0, 1, 0, 1, 0, 4'h0, 4'hA, 0, 0, 0, 1));   // underflow
    vecs.push_back(mk(0, 1, 0, 0, 1, 4'h0, 4'hA, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 1, 4'h0, 4'hA, 0, 0, 0, 1));   // set wins over clear
    vecs.push_back(mk(0, 1, 0, 0, 1, 4'h0, 4'hA, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 4'h1, 4'hA, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 4'h2, 4'hA, 0, 2, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 4'h3, 4'hA, 0, 3, 0, 0));
    vecs.push_back(mk(1, 1, 0, 1, 0, 4'h0, 4'h0, 0, 0, 0, 0));   // reset with pop

    step = 0;
    foreach (vecs[i]) begin
      apply(vecs[i], step);
      step++;
    end

    // Fill to DEPTH with random words, replace top while full, then drain.
    top = 4'h0;
    for (int i = 0; i < DEPTH; i++) begin
      d = 4'($urandom_range(0, 15));
      mdl.push_back(d);
      apply(mk(0, 1, 1, 0, 0, d, top, 0, i + 1, 0, 0), step++);
    end
    d = 4'($urandom_range(0, 15));
    top = mdl.pop_back();
    mdl.push_back(d);
    apply(mk(0, 1, 1, 1, 0, d, top, 1, DEPTH, 0, 0), step++);
    for (int i = DEPTH; i > 0; i--) begin
      top = mdl.pop_back();
      apply(mk(0, 1, 0, 1, 0, 4'h0, top, 1, i - 1, 0, 0), step++);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
